constraint_stream_checker: RTL and testbench

// - Streaming, multi-channel successor of the single-word "operand != constant" constraint check.
// - Per beat, compares NUM_CH operands against per-channel programmable constants (NE/EQ/LT/GE).
// - ANDs beat verdicts over a frame; reports one result per frame on a valid/ready output.
// - Sits between the stimulus streamer and the solver scoreboard.

---
 rtl/constraint_stream_checker_if.sv | 42 ++++
 rtl/constraint_stream_checker.sv | 200 ++++++++++++++++++++
 tb/tb_constraint_stream_checker.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/constraint_stream_checker_if.sv
// Stream and result handshake bundle for constraint_stream_checker.
// out_first_fail exists only with CONSTRAINT_STREAM_FIRSTFAIL_EN.
interface constraint_stream_checker_if #(
  parameter int WIDTH  = 38,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sat;
  logic [NUM_CH-1:0]       out_fail_mask;
  logic [CNT_W-1:0]        out_beats;
`ifdef CONSTRAINT_STREAM_FIRSTFAIL_EN
  logic [CNT_W-1:0]        out_first_fail;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sat, out_fail_mask,
    input  out_beats, out_first_fail
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sat, out_fail_mask,
    output out_beats, out_first_fail
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sat, out_fail_mask,
    input  out_beats
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sat, out_fail_mask,
    output out_beats
  );
`endif
endinterface

// File: rtl/constraint_stream_checker.sv
// Per-frame multi-channel constraint checker (NE/EQ/LT/GE per channel).
// Optional first-fail index output: CONSTRAINT_STREAM_FIRSTFAIL_EN.
module constraint_stream_checker #(
  parameter int               WIDTH      = 38,
  parameter int               NUM_CH     = 4,
  parameter logic [WIDTH-1:0] CONST_INIT = 38'h34d5a910c,
  parameter int               CNT_W      = 16,
  localparam int              SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  constraint_stream_checker_if.slave bus,
  input  logic                 i_cfg_we,
  input  logic [SEL_W-1:0]     i_cfg_sel,
  input  logic [1:0]           i_cfg_mode,
  input  logic                 i_cfg_en,
  input  logic [WIDTH-1:0]     i_cfg_const,
  output logic                 o_cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE, S_ACCUM, S_DRAIN, S_HOLD
  } state_t;

  state_t r_state, w_next;

  logic              r_live;
  logic [WIDTH-1:0]  r_const [NUM_CH];
  logic [1:0]        r_mode  [NUM_CH];
  logic [NUM_CH-1:0] r_en;

  logic              r_s1_vld, r_s1_last, r_s2_last;
  logic [NUM_CH-1:0] r_s1_pass, w_pass;

  logic              r_acc_sat;
  logic [NUM_CH-1:0] r_acc_mask;
  logic [CNT_W-1:0]  r_acc_beats, w_beats_inc;

  logic              r_out_sat;
  logic [NUM_CH-1:0] r_out_mask;
  logic [CNT_W-1:0]  r_out_beats;
  logic              r_cfg_err;

  logic w_in_ready, w_accept, w_load, w_clear, w_cfg_ok;

  function automatic logic f_cmp(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic r;
    r = 1'b0;
    unique case (m)
      2'b00: r = (a != b);
      2'b01: r = (a == b);
      2'b10: r = (a <  b);
      2'b11: r = (a >= b);
    endcase
    return r;
  endfunction

  always_comb begin
    w_pass = '1;
    for (int c = 0; c < NUM_CH; c++) begin
      w_pass[c] = !r_en[c] ||
        f_cmp(r_mode[c], bus.in_data[c*WIDTH +: WIDTH], r_const[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  // in_ready depends on registered state only, never on out_ready
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_clear    = 1'b0;
    w_in_ready = r_live &&
      (r_state == S_IDLE || r_state == S_ACCUM);
    w_accept   = bus.in_valid && w_in_ready;
    w_cfg_ok   = (r_state == S_IDLE) && !r_s1_vld;
    unique case (r_state)
      S_IDLE:
        if (w_accept) w_next = bus.in_last ? S_DRAIN : S_ACCUM;
      S_ACCUM:
        if (w_accept && bus.in_last) w_next = S_DRAIN;
      S_DRAIN:
        if (r_s2_last) begin
          w_next = S_HOLD;
          w_load = 1'b1;
        end
      S_HOLD:
        if (bus.out_ready) begin
          w_next  = S_IDLE;
          w_clear = 1'b1;
        end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_const[c] <= CONST_INIT;
        r_mode[c]  <= 2'b00;
      end
      r_en      <= '1;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= i_cfg_we && !w_cfg_ok;
      if (i_cfg_we && w_cfg_ok) begin
        r_const[i_cfg_sel] <= i_cfg_const;
        r_mode[i_cfg_sel]  <= i_cfg_mode;
        r_en[i_cfg_sel]    <= i_cfg_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_pass <= '0;
      r_s2_last <= 1'b0;
    end else begin
      r_s1_vld  <= w_accept;
      r_s1_last <= bus.in_last;
      r_s1_pass <= w_pass;
      r_s2_last <= r_s1_vld && r_s1_last;
    end
  end

  assign w_beats_inc = (&r_acc_beats) ? r_acc_beats
                                      : r_acc_beats + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_sat   <= 1'b1;
      r_acc_mask  <= '0;
      r_acc_beats <= '0;
    end else if (w_clear) begin
      r_acc_sat   <= 1'b1;
      r_acc_mask  <= '0;
      r_acc_beats <= '0;
    end else if (r_s1_vld) begin
      r_acc_sat   <= r_acc_sat & (&r_s1_pass);
      r_acc_mask  <= r_acc_mask | ~r_s1_pass;
      r_acc_beats <= w_beats_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_sat   <= 1'b0;
      r_out_mask  <= '0;
      r_out_beats <= '0;
    end else if (w_load) begin
      r_out_sat   <= r_acc_sat;
      r_out_mask  <= r_acc_mask;
      r_out_beats <= r_acc_beats;
    end
  end

`ifdef CONSTRAINT_STREAM_FIRSTFAIL_EN
  logic [CNT_W-1:0] r_acc_ff, r_out_ff;

  // r_acc_sat still high means this is the first failing beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_ff <= '1;
    end else if (w_clear) begin
      r_acc_ff <= '1;
    end else if (r_s1_vld && !(&r_s1_pass) && r_acc_sat) begin
      r_acc_ff <= r_acc_beats;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_out_ff <= '0;
    else if (w_load) r_out_ff <= r_acc_ff;
  end

  assign bus.out_first_fail = r_out_ff;
`endif

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = (r_state == S_HOLD);
  assign bus.out_sat       = r_out_sat;
  assign bus.out_fail_mask = r_out_mask;
  assign bus.out_beats     = r_out_beats;
  assign o_cfg_err         = r_cfg_err;

endmodule

// File: tb/tb_constraint_stream_checker.sv
// Randomized bench for constraint_stream_checker against a frame-level model.
// Two instances share stimulus: CNT_W=16 and CNT_W=4 (counter saturation).
module tb_constraint_stream_checker;
  localparam int W = 38;
  localparam int N = 4;
  localparam logic [W-1:0] CI = 38'h34d5a910c;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_last, out_ready;
  logic [N*W-1:0] in_data;
  logic cfg_we, cfg_en;
  logic [1:0] cfg_sel, cfg_mode;
  logic [W-1:0] cfg_const;
  logic cfg_err, cfg_err4;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]   m_const [N];
  logic [1:0]     m_mode  [N];
  logic           m_en    [N];
  int             e_n, e_ff;
  logic           e_sat;
  logic [N-1:0]   e_mask;
  logic [N*W-1:0] fr [$];

  constraint_stream_checker_if #(.WIDTH(W), .NUM_CH(N), .CNT_W(16)) bus ();
  constraint_stream_checker_if #(.WIDTH(W), .NUM_CH(N), .CNT_W(4))  bus4 ();

  assign bus.in_valid   = in_valid;
  assign bus.in_data    = in_data;
  assign bus.in_last    = in_last;
  assign bus.out_ready  = out_ready;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_data   = in_data;
  assign bus4.in_last   = in_last;
  assign bus4.out_ready = out_ready;

  constraint_stream_checker #(
    .WIDTH(W), .NUM_CH(N), .CONST_INIT(CI), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_mode(cfg_mode),
    .i_cfg_en(cfg_en), .i_cfg_const(cfg_const), .o_cfg_err(cfg_err)
  );

  constraint_stream_checker #(
    .WIDTH(W), .NUM_CH(N), .CONST_INIT(CI), .CNT_W(4)
  ) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_mode(cfg_mode),
    .i_cfg_en(cfg_en), .i_cfg_const(cfg_const), .o_cfg_err(cfg_err4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_pass(input int c, input logic [W-1:0] op);
    if (!m_en[c]) return 1'b1;
    case (m_mode[c])
      2'd0:    return op != m_const[c];
      2'd1:    return op == m_const[c];
      2'd2:    return op <  m_const[c];
      default: return op >= m_const[c];
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_op(input int c);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0:       return m_const[c];
      1:       return m_const[c] + 38'd1;
      2:       return m_const[c] - 38'd1;
      default: return r[W-1:0];
    endcase
  endfunction

  function automatic logic [N*W-1:0] rnd_beat();
    logic [N*W-1:0] d;
    d = '0;
    for (int c = 0; c < N; c++) d[c*W +: W] = rnd_op(c);
    return d;
  endfunction

  function automatic logic [W-1:0] rnd_k();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_const[c] = CI;
      m_mode[c]  = 2'd0;
      m_en[c]    = 1'b1;
    end
  endtask

  task automatic model_beat(input logic [N*W-1:0] d);
    logic f;
    f = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (!ref_pass(c, d[c*W +: W])) begin
        e_mask[c] = 1'b1;
        f = 1'b1;
      end
    end
    if (f && e_ff < 0) e_ff = e_n;
    if (f) e_sat = 1'b0;
    e_n++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_rdy",   64'(bus.in_ready), 64'd0);
    check("rst_vld",   64'(bus.out_valid), 64'd0);
    check("rst_sat",   64'(bus.out_sat), 64'd0);
    check("rst_mask",  64'(bus.out_fail_mask), 64'd0);
    check("rst_beats", 64'(bus.out_beats), 64'd0);
    check("rst_err",   64'(cfg_err), 64'd0);
`ifdef CONSTRAINT_STREAM_FIRSTFAIL_EN
    check("rst_ff",    64'(bus.out_first_fail), 64'd0);
`endif
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    check("rdy_in_rel", 64'(bus.in_ready), 64'd0);
    tick();
    check("rdy_rise", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic do_cfg(input int sel, input logic [1:0] mode,
                        input logic en, input logic [W-1:0] k,
                        input bit ok);
    cfg_we    = 1'b1;
    cfg_sel   = 2'(sel);
    cfg_mode  = mode;
    cfg_en    = en;
    cfg_const = k;
    tick();
    cfg_we = 1'b0;
    check("cfg_err", 64'(cfg_err), ok ? 64'd0 : 64'd1);
    if (ok) begin
      m_const[sel] = k;
      m_mode[sel]  = mode;
      m_en[sel]    = en;
    end
    tick();
    check("cfg_err_pulse", 64'(cfg_err), 64'd0);
  endtask

  task automatic send_frame(input int drop_at, input bit first_cfg);
    int t;
    int s;
    e_n = 0; e_ff = -1; e_sat = 1'b1; e_mask = '0;
    for (int b = 0; b < fr.size(); b++) begin
      in_data  = fr[b];
      in_last  = (b == fr.size() - 1);
      in_valid = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 50) begin
        tick();
        t++;
      end
      if (t >= 50) check("rdy_timeout", 64'(bus.in_ready), 64'd1);
      if (b == 0 && first_cfg) cfg_we = 1'b1;
      model_beat(fr[b]);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (b == 0 && first_cfg) begin
        cfg_we = 1'b0;
        check("cfg_first_err", 64'(cfg_err), 64'd0);
        s = int'(cfg_sel);
        m_const[s] = cfg_const;
        m_mode[s]  = cfg_mode;
        m_en[s]    = cfg_en;
      end
      if (b == drop_at && b < fr.size() - 1)
        do_cfg($urandom_range(0, 3), 2'($urandom_range(0, 3)),
               1'b0, rnd_k(), 1'b0);
      else if (b < fr.size() - 1 && $urandom_range(0, 3) == 0)
        tick();
    end
  endtask

  task automatic get_result(input int hold);
    logic [15:0] b16, f16;
    logic [3:0]  b4, f4;
    b16 = 16'(e_n);
    b4  = (e_n > 15) ? 4'hF : 4'(e_n);
    f16 = e_sat ? 16'hFFFF : 16'(e_ff);
    f4  = e_sat ? 4'hF : ((e_ff > 15) ? 4'hF : 4'(e_ff));
    check("drain_rdy", 64'(bus.in_ready), 64'd0);
    tick();
    check("lat_n1", 64'(bus.out_valid), 64'd0);
    tick();
    check("lat_n2", 64'(bus.out_valid), 64'd1);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) tick();
      check("vld",    64'(bus.out_valid), 64'd1);
      check("rdy",    64'(bus.in_ready), 64'd0);
      check("sat",    64'(bus.out_sat), 64'(e_sat));
      check("mask",   64'(bus.out_fail_mask), 64'(e_mask));
      check("beats",  64'(bus.out_beats), 64'(b16));
      check("beats4", 64'(bus4.out_beats), 64'(b4));
      check("vld4",   64'(bus4.out_valid), 64'd1);
`ifdef CONSTRAINT_STREAM_FIRSTFAIL_EN
      check("ff",     64'(bus.out_first_fail), 64'(f16));
      check("ff4",    64'(bus4.out_first_fail), 64'(f4));
`else
      if (f16 != 16'hFFFF) check("ff_sat_consistency",
                                 64'(bus.out_sat), 64'd0);
      if (f4 == 4'hF && e_ff >= 0 && e_ff < 15)
        check("ff4_model", 64'(f4), 64'(e_ff));
`endif
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rel_vld", 64'(bus.out_valid), 64'd0);
    check("rel_rdy", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] k;
    int len, drop;
    bit fc;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_data = '0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_mode = 2'd0;
    cfg_en = 1'b0; cfg_const = '0; rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    fr.delete();
    fr.push_back({38'd0, 38'd0, 38'd0, CI});
    send_frame(-1, 1'b0);
    get_result(0);

    do_cfg(2, 2'b01, 1'b1, 38'd5, 1'b1);
    fr.delete();
    for (int b = 0; b < 3; b++) fr.push_back({38'd1, 38'd5, 38'd1, 38'd1});
    send_frame(-1, 1'b0);
    get_result(10);

    fr.delete();
    for (int b = 0; b < 4; b++) fr.push_back(rnd_beat());
    send_frame(1, 1'b0);
    get_result(1);

    cfg_sel = 2'd0; cfg_mode = 2'b10; cfg_en = 1'b1; cfg_const = rnd_k();
    fr.delete();
    for (int b = 0; b < 3; b++) fr.push_back(rnd_beat());
    send_frame(-1, 1'b1);
    get_result(0);

    in_last = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_data  = rnd_beat();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    do_reset();
    fr.delete();
    for (int b = 0; b < 3; b++) fr.push_back(rnd_beat());
    send_frame(-1, 1'b0);
    get_result(0);

    k = 38'h12345;
    for (int c = 1; c < N; c++) do_cfg(c, 2'b00, 1'b0, rnd_k(), 1'b1);
    do_cfg(0, 2'b01, 1'b1, k, 1'b1);
    fr.delete();
    for (int b = 0; b < 20; b++) begin
      logic [N*W-1:0] d;
      d = rnd_beat();
      d[W-1:0] = (b == 7) ? k + 38'd1 : k;
      fr.push_back(d);
    end
    send_frame(-1, 1'b0);
    check("ff_model_idx", 64'(e_ff), 64'd7);
    get_result(0);

    do_cfg(0, 2'b01, 1'b0, k, 1'b1);
    fr.delete();
    for (int b = 0; b < 2; b++) fr.push_back(rnd_beat());
    send_frame(-1, 1'b0);
    get_result(0);

    do_reset();
    for (int f = 0; f < 25; f++) begin
      int nc;
      nc = $urandom_range(0, 2);
      for (int j = 0; j < nc; j++)
        do_cfg($urandom_range(0, 3), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 4) != 0), rnd_k(), 1'b1);
      len = $urandom_range(1, 20);
      fr.delete();
      for (int b = 0; b < len; b++) fr.push_back(rnd_beat());
      drop = (len > 2 && $urandom_range(0, 3) == 0) ? 1 : -1;
      fc = ($urandom_range(0, 5) == 0);
      if (fc) begin
        cfg_sel   = 2'($urandom_range(0, 3));
        cfg_mode  = 2'($urandom_range(0, 3));
        cfg_en    = 1'b1;
        cfg_const = rnd_k();
      end
      send_frame(drop, fc);
      get_result($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
